pagerank_host_cfg: RTL and testbench

Host-side initiator for the PageRank accelerator request/response protocol. It takes one configuration command (G base, R base, node count) from a control port. It converts that command into the ordered register-write sequence the PageRank scheduler expects: write base_G, write base_R, write size, then write start. It issues one request at a time, waits for each response, flags protocol errors, and reports completion upstream.

---
 rtl/pagerank_host_cfg.sv | 161 ++++++++++++++++
 tb/tb_pagerank_host_cfg.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/pagerank_host_cfg.sv
// Host-side initiator: turns one go command into the base_G/base_R/size/start write sequence.
// Optional `PAGERANK_HOST_POLL_EN adds read-polling of addr 0 until the accelerator reports done.
module pagerank_host_cfg #(
    parameter int nbits = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go_val,
    output logic             go_rdy,
    input  logic [31:0]      go_base_g,
    input  logic [31:0]      go_base_r,
    input  logic [nbits-1:0] go_size,
    output logic [64:0]      req_msg,
    output logic             req_val,
    input  logic             req_rdy,
    input  logic [32:0]      resp_msg,
    input  logic             resp_val,
    output logic             resp_rdy,
    output logic             done,
    output logic             err,
    output logic [15:0]      poll_count
);

    typedef enum logic [2:0] {
        IDLE, REQ, WAIT, POLL_REQ, POLL_WAIT, DONE
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic             err_q, err_d;
    logic [31:0]      g_q, g_d, r_q, r_d;
    logic [nbits-1:0] s_q, s_d;
    logic [64:0]      req_msg_q, req_msg_d;
`ifdef PAGERANK_HOST_POLL_EN
    logic [15:0]      pc_q, pc_d;
`endif

    // Only the done bit of response data is ever inspected.
    logic unused_resp_data;
    assign unused_resp_data = ^resp_msg[31:1];

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        err_d    = err_q;
        g_d      = g_q;
        r_d      = r_q;
        s_d      = s_q;
`ifdef PAGERANK_HOST_POLL_EN
        pc_d     = pc_q;
`endif
        go_rdy   = 1'b0;
        req_val  = 1'b0;
        resp_rdy = 1'b0;
        done     = 1'b0;
        case (state_q)
            IDLE: begin
                go_rdy = 1'b1;
                if (go_val) begin
                    g_d     = go_base_g;
                    r_d     = go_base_r;
                    s_d     = go_size;
                    idx_d   = 2'd0;
                    err_d   = 1'b0;
`ifdef PAGERANK_HOST_POLL_EN
                    pc_d    = 16'd0;
`endif
                    state_d = REQ;
                end
            end
            REQ: begin
                req_val = 1'b1;
                if (req_rdy) state_d = WAIT;
            end
            WAIT: begin
                resp_rdy = 1'b1;
                if (resp_val) begin
                    if (!resp_msg[32]) err_d = 1'b1;
                    if (idx_q != 2'd3) begin
                        idx_d   = idx_q + 2'd1;
                        state_d = REQ;
                    end else begin
`ifdef PAGERANK_HOST_POLL_EN
                        state_d = POLL_REQ;
`else
                        state_d = DONE;
`endif
                    end
                end
            end
`ifdef PAGERANK_HOST_POLL_EN
            POLL_REQ: begin
                req_val = 1'b1;
                if (req_rdy) begin
                    if (pc_q != 16'hFFFF) pc_d = pc_q + 16'd1;
                    state_d = POLL_WAIT;
                end
            end
            POLL_WAIT: begin
                resp_rdy = 1'b1;
                if (resp_val) begin
                    if (resp_msg[32]) err_d = 1'b1;
                    state_d = resp_msg[0] ? DONE : POLL_REQ;
                end
            end
`endif
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Message is registered from the next state so it is valid in the first REQ cycle.
        // A poll read (type 0, addr 0, data 0) is all zeros, same as the idle value.
        req_msg_d = '0;
        if (state_d == REQ) begin
            case (idx_d)
                2'd0:    req_msg_d = {1'b1, 32'd1, g_d};
                2'd1:    req_msg_d = {1'b1, 32'd2, r_d};
                2'd2:    req_msg_d = {1'b1, 32'd3, 32'(s_d)};
                default: req_msg_d = {1'b1, 32'd0, 32'd1};
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            idx_q     <= 2'd0;
            err_q     <= 1'b0;
            g_q       <= '0;
            r_q       <= '0;
            s_q       <= '0;
            req_msg_q <= '0;
`ifdef PAGERANK_HOST_POLL_EN
            pc_q      <= 16'd0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            err_q     <= err_d;
            g_q       <= g_d;
            r_q       <= r_d;
            s_q       <= s_d;
            req_msg_q <= req_msg_d;
`ifdef PAGERANK_HOST_POLL_EN
            pc_q      <= pc_d;
`endif
        end
    end

    assign req_msg = req_msg_q;
    assign err     = err_q;
`ifdef PAGERANK_HOST_POLL_EN
    assign poll_count = pc_q;
`else
    assign poll_count = 16'd0;
`endif

endmodule

// File: tb/tb_pagerank_host_cfg.sv
// Randomized bench for pagerank_host_cfg: bench acts as the accelerator responder and
// checks each cycle against a transaction-list model of the expected request sequence.
module tb_pagerank_host_cfg;

`ifdef PAGERANK_HOST_POLL_EN
    localparam bit POLL = 1'b1;
`else
    localparam bit POLL = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        go_val;
    logic        go_rdy;
    logic [31:0] go_base_g, go_base_r, go_size;
    logic [64:0] req_msg;
    logic        req_val, req_rdy;
    logic [32:0] resp_msg;
    logic        resp_val, resp_rdy;
    logic        done, err;
    logic [15:0] poll_count;

    int nvec = 0;
    int nmis = 0;

    pagerank_host_cfg #(.nbits(32)) dut (
        .clk(clk), .reset(reset),
        .go_val(go_val), .go_rdy(go_rdy),
        .go_base_g(go_base_g), .go_base_r(go_base_r), .go_size(go_size),
        .req_msg(req_msg), .req_val(req_val), .req_rdy(req_rdy),
        .resp_msg(resp_msg), .resp_val(resp_val), .resp_rdy(resp_rdy),
        .done(done), .err(err), .poll_count(poll_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nmis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Idle-state probe: responses offered while idle must be ignored.
    task automatic stray_idle(input logic exp_err);
        for (int i = 0; i < 3; i++) begin
            resp_val = 1'b1;
            resp_msg = {1'($urandom), 32'($urandom)};
            @(negedge clk);
            chk("stray resp_rdy", resp_rdy, 0);
            chk("stray go_rdy", go_rdy, 1);
            chk("stray req_val", req_val, 0);
            chk("stray err", err, exp_err);
            chk("stray done", done, 0);
        end
        resp_val = 1'b0;
    endtask

    // One command. bp_txn/bp_n force backpressure on one transaction; rnd adds random
    // stalls; err_txn gets a wrong-type response; abort_txn asserts reset in its WAIT.
    task automatic run_seq(input logic [31:0] g, input logic [31:0] r, input logic [31:0] s,
                           input int bp_txn, input int bp_n, input bit rnd,
                           input int err_txn, input int abort_txn, input int npoll_dir);
        logic [64:0] exp_q[$];
        int bp[$];
        int dl[$];
        int npoll, ntx, exp_done, cyc, t, ph, left;
        bit exp_err, err_pend, typ;
        logic [31:0] data;

        exp_q.push_back({1'b1, 32'd1, g});
        exp_q.push_back({1'b1, 32'd2, r});
        exp_q.push_back({1'b1, 32'd3, s});
        exp_q.push_back({1'b1, 32'd0, 32'd1});
        npoll = POLL ? ((npoll_dir > 0) ? npoll_dir : int'($urandom_range(1, 4))) : 0;
        for (int i = 0; i < npoll; i++) exp_q.push_back(65'd0);
        ntx = exp_q.size();
        exp_done = 1;
        for (int i = 0; i < ntx; i++) begin
            bp.push_back(rnd ? int'($urandom_range(0, 3)) : 0);
            if (i == bp_txn) bp[i] = bp_n;
            dl.push_back(rnd ? int'($urandom_range(0, 2)) : 0);
            exp_done += 2 + bp[i] + dl[i];
        end

        chk("go_rdy idle", go_rdy, 1);
        go_val = 1'b1; go_base_g = g; go_base_r = r; go_size = s;
        resp_val = 1'b0; req_rdy = 1'b0;
        @(negedge clk);
        go_val = 1'b0;
        go_base_g = $urandom; go_base_r = $urandom; go_size = $urandom;

        cyc = 1; t = 0; ph = 0; left = bp[0]; exp_err = 1'b0; err_pend = 1'b0;
        forever begin
            if (cyc > 400) begin
                chk("timeout waiting for done", 0, 1);
                break;
            end
            chk("go_rdy busy", go_rdy, 0);
            chk("err", err, exp_err);
            if (ph == 2) begin
                chk("done", done, 1);
                chk("done cycle", 65'(cyc), 65'(exp_done));
                chk("poll_count", poll_count, 65'(npoll));
                chk("req_val at done", req_val, 0);
                resp_val = 1'b0; req_rdy = 1'b0;
                @(negedge clk);
                break;
            end
            chk("done early", done, 0);
            if (ph == 0) begin
                chk("req_val", req_val, 1);
                chk("req_msg", req_msg, exp_q[t]);
                chk("resp_rdy in req", resp_rdy, 0);
                resp_val = 1'($urandom);
                resp_msg = {1'($urandom), 32'($urandom)};
                req_rdy = (left == 0);
                if (left == 0) begin
                    ph = 1;
                    left = dl[t];
                end else left--;
            end else begin
                chk("req_val in wait", req_val, 0);
                chk("resp_rdy", resp_rdy, 1);
                req_rdy = 1'($urandom);
                if (t == abort_txn) begin
                    reset = 1'b1;
                    resp_val = 1'b0;
                    @(negedge clk);
                    chk("abort go_rdy", go_rdy, 1);
                    chk("abort req_val", req_val, 0);
                    chk("abort err", err, 0);
                    chk("abort resp_rdy", resp_rdy, 0);
                    chk("abort req_msg", req_msg, 0);
                    reset = 1'b0; req_rdy = 1'b0;
                    @(negedge clk);
                    return;
                end
                if (left > 0) begin
                    resp_val = 1'b0;
                    left--;
                end else begin
                    typ = (t < 4);
                    if (t == err_txn) begin
                        typ = ~typ;
                        err_pend = 1'b1;
                    end
                    data = $urandom;
                    if (t >= 4) data[0] = (t == ntx - 1);
                    resp_val = 1'b1;
                    resp_msg = {typ, data};
                    t++;
                    if (t == ntx) ph = 2;
                    else begin
                        ph = 0;
                        left = bp[t];
                    end
                end
            end
            @(negedge clk);
            cyc++;
            if (err_pend) exp_err = 1'b1;
        end
    endtask

    initial begin
        reset = 1'b1; go_val = 1'b0; go_base_g = '0; go_base_r = '0; go_size = '0;
        req_rdy = 1'b0; resp_val = 1'b0; resp_msg = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst go_rdy", go_rdy, 1);
        chk("rst req_val", req_val, 0);
        chk("rst req_msg", req_msg, 0);
        chk("rst resp_rdy", resp_rdy, 0);
        chk("rst done", done, 0);
        chk("rst err", err, 0);
        chk("rst poll_count", poll_count, 0);
        reset = 1'b0;
        @(negedge clk);

        stray_idle(1'b0);
        // basic, then backpressure of 3 on the second request, then a bad third response
        run_seq(32'h100, 32'h200, 32'd8, -1, 0, 1'b0, -1, -1, 3);
        run_seq(32'h100, 32'h200, 32'd8, 1, 3, 1'b0, -1, -1, 3);
        run_seq(32'h100, 32'h200, 32'd8, -1, 0, 1'b0, 2, -1, 3);
        stray_idle(1'b1);
        run_seq(32'h300, 32'h400, 32'd5, -1, 0, 1'b0, -1, -1, 2);
        // reset while waiting on the size write, then a clean restart
        run_seq(32'hA0, 32'hB0, 32'd4, -1, 0, 1'b0, 0, 2, 0);
        run_seq(32'hC0, 32'hD0, 32'd6, -1, 0, 1'b0, -1, -1, 0);
        for (int k = 0; k < 20; k++) begin
            run_seq($urandom, $urandom, $urandom, -1, 0, 1'b1,
                    int'($urandom_range(0, 11)) - 4, -1, 0);
        end
        stray_idle(err);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
